// File: rtl/ics_pkg.sv
// ics_pkg: FSM states, register map, voice record and saturation helper shared by ics_voice_engine.
package ics_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, ACC, DONE} state_t;
  localparam logic [3:0] SEL_CTRL = 4'd0;
  localparam logic [3:0] SEL_START_LO = 4'd1;
  localparam logic [3:0] SEL_START_HI = 4'd2;
  localparam logic [3:0] SEL_END_LO = 4'd3;
  localparam logic [3:0] SEL_END_HI = 4'd4;
  localparam logic [3:0] SEL_LOOP_LO = 4'd5;
  localparam logic [3:0] SEL_LOOP_HI = 4'd6;
  localparam logic [3:0] SEL_INCR = 4'd7;
  localparam logic [3:0] SEL_VOL = 4'd8;
  typedef struct packed {
    logic loop_en;
    logic [15:0] incr;
    logic [7:0] vol_r;
    logic [7:0] vol_l;
  } voice_t;
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    return v > 32'sd32767 ? 16'sh7fff : v < -32'sd32768 ? 16'sh8000 : v[15:0];
  endfunction
endpackage

// File: rtl/ics_voice_regs.sv
// ics_voice_regs: per-voice register file; host writes override same-cycle engine updates.
// Loop storage exists only when ICS_VOICE_LOOP_EN is defined.
module ics_voice_regs import ics_pkg::*; #(
  parameter int NUM_VOICES = 32,
  parameter int ADDR_W = 24,
  parameter int FRAC_W = 10,
  localparam int VW = $clog2(NUM_VOICES),
  localparam int PW = ADDR_W + FRAC_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reg_we,
  input  logic [VW-1:0]         reg_voice,
  input  logic [3:0]            reg_sel,
  input  logic [15:0]           reg_wdata,
  input  logic                  eng_we,
  input  logic [VW-1:0]         eng_voice,
  input  logic [PW-1:0]         eng_pos,
  input  logic                  eng_active,
  output voice_t                cfg,
  output logic [ADDR_W-1:0]     end_a,
  output logic [ADDR_W-1:0]     loop_a,
  output logic [PW-1:0]         pos,
  output logic [NUM_VOICES-1:0] active
);
  voice_t cfg_q [NUM_VOICES];
  logic [ADDR_W-1:0] start_q [NUM_VOICES];
  logic [ADDR_W-1:0] end_q [NUM_VOICES];
  logic [PW-1:0] pos_q [NUM_VOICES];
`ifdef ICS_VOICE_LOOP_EN
  logic [ADDR_W-1:0] loop_q [NUM_VOICES];
  assign loop_a = loop_q[eng_voice];
`else
  assign loop_a = '0;
`endif
  assign cfg = cfg_q[eng_voice];
  assign end_a = end_q[eng_voice];
  assign pos = pos_q[eng_voice];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        cfg_q[i] <= '0;
        start_q[i] <= '0;
        end_q[i] <= '0;
        pos_q[i] <= '0;
`ifdef ICS_VOICE_LOOP_EN
        loop_q[i] <= '0;
`endif
      end
      active <= '0;
    end else begin
      if (eng_we) begin
        pos_q[eng_voice] <= eng_pos;
        active[eng_voice] <= eng_active;
      end
      // later assignments win, so host fields override the engine update
      if (reg_we)
        case (reg_sel)
          SEL_CTRL: begin
            active[reg_voice] <= reg_wdata[0];
            if (reg_wdata[0]) pos_q[reg_voice] <= {start_q[reg_voice], FRAC_W'(0)};
`ifdef ICS_VOICE_LOOP_EN
            cfg_q[reg_voice].loop_en <= reg_wdata[1];
`endif
          end
          SEL_START_LO: start_q[reg_voice][15:0] <= reg_wdata;
          SEL_START_HI: start_q[reg_voice][ADDR_W-1:16] <= reg_wdata[ADDR_W-17:0];
          SEL_END_LO: end_q[reg_voice][15:0] <= reg_wdata;
          SEL_END_HI: end_q[reg_voice][ADDR_W-1:16] <= reg_wdata[ADDR_W-17:0];
`ifdef ICS_VOICE_LOOP_EN
          SEL_LOOP_LO: loop_q[reg_voice][15:0] <= reg_wdata;
          SEL_LOOP_HI: loop_q[reg_voice][ADDR_W-1:16] <= reg_wdata[ADDR_W-17:0];
`endif
          SEL_INCR: cfg_q[reg_voice].incr <= reg_wdata;
          SEL_VOL: {cfg_q[reg_voice].vol_r, cfg_q[reg_voice].vol_l} <= reg_wdata;
          default: ;
        endcase
    end
  end
endmodule

// File: rtl/ics_voice_engine.sv
// ics_voice_engine: wavetable voice mixer, one SDRAM fetch per active voice per output frame.
// Define ICS_VOICE_LOOP_EN to build per-voice loop points.
module ics_voice_engine import ics_pkg::*; #(
  parameter int NUM_VOICES = 32,
  parameter int ADDR_W = 24,
  parameter int FRAC_W = 10,
  parameter int MIX_W = 24,
  parameter logic [28:0] SAMPLE_BASE = 29'h620000,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_tick,
  input  logic                    reg_we,
  input  logic [VW-1:0]           reg_voice,
  input  logic [3:0]              reg_sel,
  input  logic [15:0]             reg_wdata,
  output logic                    mem_rd,
  output logic [28:0]             mem_addr,
  input  logic                    mem_ready,
  input  logic [15:0]             mem_data,
  output logic signed [15:0]      sample_l,
  output logic signed [15:0]      sample_r,
  output logic                    sample_valid,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    overrun
);
  localparam int PW = ADDR_W + FRAC_W;
  state_t state;
  logic [VW-1:0] idx;
  logic signed [MIX_W-1:0] acc_l, acc_r;
  logic signed [15:0] data_q;
  voice_t cfg;
  logic [ADDR_W-1:0] end_a, loop_a;
  logic [PW-1:0] pos, pos_inc, eng_pos;
  logic over, eng_active, last;
  logic signed [24:0] prod_l, prod_r;
  ics_voice_regs #(.NUM_VOICES(NUM_VOICES), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W)) u_regs (
    .clk(clk), .reset_n(reset_n), .reg_we(reg_we), .reg_voice(reg_voice), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .eng_we(state == ACC), .eng_voice(idx), .eng_pos(eng_pos),
    .eng_active(eng_active), .cfg(cfg), .end_a(end_a), .loop_a(loop_a), .pos(pos),
    .active(voice_active)
  );
  assign last = idx == VW'(NUM_VOICES - 1);
  assign pos_inc = pos + PW'(cfg.incr);
  assign over = pos_inc[PW-1:FRAC_W] > end_a;
  assign eng_pos = !over ? pos_inc : cfg.loop_en ? {loop_a, FRAC_W'(0)} : pos;
  // reads the live flag so a key-off during the fetch is not undone
  assign eng_active = voice_active[idx] & (!over | cfg.loop_en);
  assign prod_l = data_q * $signed({1'b0, cfg.vol_l});
  assign prod_r = data_q * $signed({1'b0, cfg.vol_r});
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      acc_l <= '0;
      acc_r <= '0;
      data_q <= '0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      sample_l <= '0;
      sample_r <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_tick) begin
          state <= SCAN;
          idx <= '0;
          acc_l <= '0;
          acc_r <= '0;
        end
        SCAN: if (voice_active[idx]) begin
          state <= REQ;
          mem_rd <= 1'b1;
          mem_addr <= SAMPLE_BASE + 29'(pos[PW-1:FRAC_W]);
        end else if (last) state <= DONE;
        else idx <= idx + 1'b1;
        REQ, WAIT: if (mem_ready) begin
          mem_rd <= 1'b0;
          data_q <= mem_data;
          state <= ACC;
        end else state <= WAIT;
        ACC: begin
          acc_l <= acc_l + MIX_W'(prod_l >>> 8);
          acc_r <= acc_r + MIX_W'(prod_r >>> 8);
          idx <= idx + 1'b1;
          state <= last ? DONE : SCAN;
        end
        DONE: begin
          sample_l <= sat16(32'(acc_l));
          sample_r <= sat16(32'(acc_r));
          sample_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ics_voice_engine.sv
// tb_ics_voice_engine: directed vector and sequence bench for ics_voice_engine (default parameters).
module tb_ics_voice_engine;
  logic clk = 0, reset_n = 0, sample_tick = 0, reg_we = 0, mem_ready = 0;
  logic [4:0] reg_voice = 0;
  logic [3:0] reg_sel = 0;
  logic [15:0] reg_wdata = 0, mem_data = 0;
  logic mem_rd, sample_valid, overrun;
  logic [28:0] mem_addr;
  logic signed [15:0] sample_l, sample_r;
  logic [31:0] voice_active;
  int n_err = 0, n_chk = 0, valid_cnt = 0, mem_lat = 2;
  logic [15:0] mem_val = 0, last_l = 0, last_r = 0;
  logic [28:0] addr_log[$];
  typedef struct {logic [15:0] data, vol, exp_l, exp_r;} vec_t;
  vec_t vecs[8];
  logic [28:0] exp_a[6];
  int exp_n, n, n0;

  ics_voice_engine dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .reg_we(reg_we),
    .reg_voice(reg_voice), .reg_sel(reg_sel), .reg_wdata(reg_wdata), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data), .sample_l(sample_l),
    .sample_r(sample_r), .sample_valid(sample_valid), .voice_active(voice_active),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    if (mem_rd && !mem_ready) begin
      addr_log.push_back(mem_addr);
      repeat (mem_lat) @(posedge clk);
      #1 mem_ready = 1; mem_data = mem_val;
      @(posedge clk); #1 mem_ready = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (sample_valid) begin
      valid_cnt++;
      last_l = sample_l;
      last_r = sample_r;
    end
  end

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [4:0] v, input logic [3:0] s, input logic [15:0] d);
    reg_we = 1; reg_voice = v; reg_sel = s; reg_wdata = d;
    cyc(1);
    reg_we = 0;
  endtask

  task automatic tick();
    sample_tick = 1;
    cyc(1);
    sample_tick = 0;
  endtask

  task automatic wait_valid(input int c0);
    for (int k = 0; k < 5000 && valid_cnt == c0; k++) cyc(1);
    chk("frame_done", 64'(valid_cnt != c0), 1);
  endtask

  task automatic wait_rd();
    for (int k = 0; k < 200 && !mem_rd; k++) cyc(1);
    chk("rd_seen", 64'(mem_rd), 1);
  endtask

  task automatic run_frame();
    int c0;
    c0 = valid_cnt;
    tick();
    wait_valid(c0);
  endtask

  initial begin
    vecs[0] = '{16'h4000, 16'h8080, 16'h2000, 16'h2000};
    vecs[1] = '{16'h4000, 16'hFF00, 16'h0000, 16'h3FC0};
    vecs[2] = '{16'hC000, 16'h0080, 16'hE000, 16'h0000};
    vecs[3] = '{16'h0001, 16'h0101, 16'h0000, 16'h0000};
    vecs[4] = '{16'hFFFF, 16'h0101, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h7F7F, 16'h7F7F};
    vecs[6] = '{16'h8000, 16'hFFFF, 16'h8080, 16'h8080};
    vecs[7] = '{16'h1234, 16'h0010, 16'h0123, 16'h0000};

    cyc(3);
    chk("rst_mem_rd", 64'(mem_rd), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_sample_l", 64'(sample_l), 0);
    chk("rst_sample_r", 64'(sample_r), 0);
    chk("rst_valid", 64'(sample_valid), 0);
    chk("rst_active", 64'(voice_active), 0);
    chk("rst_overrun", 64'(overrun), 0);
    reset_n = 1;
    cyc(2);

    // mixing vectors: voice 0 parked at 0x100 with zero increment
    wr(0, 1, 16'h0100);
    wr(0, 3, 16'h0100);
    wr(0, 7, 16'h0000);
    wr(0, 0, 16'h0001);
    chk("keyon_active", 64'(voice_active), 1);
    for (int i = 0; i < 8; i++) begin
      wr(0, 8, vecs[i].vol);
      mem_val = vecs[i].data;
      n = addr_log.size();
      run_frame();
      chk($sformatf("vec%0d_l", i), 64'(last_l), 64'(vecs[i].exp_l));
      chk($sformatf("vec%0d_r", i), 64'(last_r), 64'(vecs[i].exp_r));
      chk($sformatf("vec%0d_addr", i), 64'(addr_log.size() > n ? addr_log[n] : 29'h0), 64'h620100);
    end

    // one-shot playback to end
    wr(0, 3, 16'h0103);
    wr(0, 7, 16'h0400);
    wr(0, 8, 16'h8080);
    wr(0, 0, 16'h0001);
    mem_val = 16'h4000;
    n = addr_log.size();
    for (int i = 0; i < 5; i++) begin
      run_frame();
      chk($sformatf("once%0d_l", i), 64'(last_l), i < 4 ? 64'h2000 : 64'h0);
    end
    chk("once_active", 64'(voice_active[0]), 0);
    chk("once_fetches", 64'(addr_log.size() - n), 4);
    for (int i = 0; i < 4 && n + i < addr_log.size(); i++)
      chk($sformatf("once_addr%0d", i), 64'(addr_log[n+i]), 64'(29'h620100 + 29'(i)));

    // loop point (ignored when loops are not built)
`ifdef ICS_VOICE_LOOP_EN
    exp_n = 6;
    exp_a = '{29'h620100, 29'h620101, 29'h620102, 29'h620103, 29'h620101, 29'h620102};
`else
    exp_n = 4;
    exp_a = '{29'h620100, 29'h620101, 29'h620102, 29'h620103, 29'h0, 29'h0};
`endif
    wr(0, 5, 16'h0101);
    wr(0, 0, 16'h0003);
    n = addr_log.size();
    for (int i = 0; i < 6; i++) begin
      run_frame();
      chk($sformatf("loop%0d_l", i), 64'(last_l), i < exp_n ? 64'h2000 : 64'h0);
    end
    chk("loop_fetches", 64'(addr_log.size() - n), 64'(exp_n));
    for (int i = 0; i < exp_n && n + i < addr_log.size(); i++)
      chk($sformatf("loop_addr%0d", i), 64'(addr_log[n+i]), 64'(exp_a[i]));
    chk("loop_active", 64'(voice_active[0]), exp_n == 6 ? 64'h1 : 64'h0);

    // half-rate increment repeats each address twice
    wr(0, 3, 16'h01FF);
    wr(0, 7, 16'h0200);
    wr(0, 0, 16'h0001);
    n = addr_log.size();
    for (int i = 0; i < 4; i++) run_frame();
    chk("half_fetches", 64'(addr_log.size() - n), 4);
    for (int i = 0; i < 4 && n + i < addr_log.size(); i++)
      chk($sformatf("half_addr%0d", i), 64'(addr_log[n+i]), 64'(29'h620100 + 29'(i / 2)));

    // all voices at full scale: saturation both ways
    for (int v = 0; v < 32; v++) begin
      wr(5'(v), 1, 16'h0200);
      wr(5'(v), 3, 16'h0FFF);
      wr(5'(v), 7, 16'h0000);
      wr(5'(v), 8, 16'hFFFF);
      wr(5'(v), 0, 16'h0001);
    end
    chk("all_active", 64'(voice_active), 64'hFFFFFFFF);
    mem_val = 16'h7FFF;
    n = addr_log.size();
    run_frame();
    chk("sat_pos_l", 64'(last_l), 64'h7FFF);
    chk("sat_pos_r", 64'(last_r), 64'h7FFF);
    chk("sat_fetches", 64'(addr_log.size() - n), 32);
    mem_val = 16'h8000;
    run_frame();
    chk("sat_neg_l", 64'(last_l), 64'h8000);
    chk("sat_neg_r", 64'(last_r), 64'h8000);
    for (int v = 0; v < 32; v++) wr(5'(v), 0, 16'h0000);
    chk("keyoff_all", 64'(voice_active), 0);
    n = addr_log.size();
    run_frame();
    chk("silent_l", 64'(last_l), 0);
    chk("silent_fetches", 64'(addr_log.size() - n), 0);

    // tick during a slow fetch
    wr(0, 8, 16'h8080);
    wr(0, 0, 16'h0001);
    mem_lat = 2000;
    mem_val = 16'h4000;
    chk("pre_overrun", 64'(overrun), 0);
    n0 = valid_cnt;
    tick();
    wait_rd();
    cyc(3);
    tick();
    wait_valid(n0);
    cyc(5);
    chk("overrun", 64'(overrun), 1);
    chk("single_valid", 64'(valid_cnt - n0), 1);
    chk("slow_l", 64'(last_l), 64'h2000);
    chk("slow_addr", 64'(mem_addr), 64'h620200);

    // key-off while waiting on memory still mixes the sample
    mem_lat = 20;
    n0 = valid_cnt;
    tick();
    wait_rd();
    cyc(2);
    wr(0, 0, 16'h0000);
    wait_valid(n0);
    chk("koff_wait_l", 64'(last_l), 64'h2000);
    chk("koff_wait_active", 64'(voice_active[0]), 0);

    // reset during a fetch, late mem_ready after release
    wr(0, 0, 16'h0001);
    mem_lat = 5;
    n0 = valid_cnt;
    tick();
    wait_rd();
    cyc(1);
    reset_n = 0;
    cyc(1);
    chk("rst_wait_rd", 64'(mem_rd), 0);
    reset_n = 1;
    cyc(12);
    chk("rst_wait_valid", 64'(valid_cnt - n0), 0);
    chk("rst_wait_mem_rd", 64'(mem_rd), 0);
    chk("rst_wait_addr", 64'(mem_addr), 0);
    chk("rst_wait_l", 64'(sample_l), 0);
    chk("rst_wait_active", 64'(voice_active), 0);
    chk("rst_wait_overrun", 64'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ics_voice_engine.md
ICS_VOICE_ENGINE -- requirements
Module: ics_voice_engine

Interface
REQ-001 Parameter NUM_VOICES, default 32, voice count (2..64); VW = $clog2(NUM_VOICES).
REQ-002 Parameter ADDR_W, default 24, integer sample-address width.
REQ-003 Parameter FRAC_W, default 10, fractional position bits; increment is 16-bit unsigned (16-FRAC_W).FRAC_W fixed point.
REQ-004 Parameter MIX_W, default 24, signed accumulator width.
REQ-005 Parameter SAMPLE_BASE, default 29'h620000, word offset of wave ROM in SDRAM.
REQ-006 clk  in  1  sole clock, all logic rising-edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 sample_tick  in  1  one-cycle output-rate strobe (~33 kHz).
REQ-009 reg_we  in  1  host register write strobe.
REQ-010 reg_voice  in  VW  target voice.
REQ-011 reg_sel  in  4  register: 0 ctrl{bit1 loop, bit0 key-on}, 1/2 start lo/hi, 3/4 end lo/hi, 5/6 loop lo/hi, 7 incr, 8 vol{R[15:8],L[7:0]}.
REQ-012 reg_wdata  in  16  write data; hi halves use bits [ADDR_W-17:0].
REQ-013 mem_rd  out  1  read request, held until mem_ready.
REQ-014 mem_addr  out  29  word address.
REQ-015 mem_ready  in  1  one-cycle data-valid pulse.
REQ-016 mem_data  in  16  signed PCM sample.
REQ-017 sample_l, sample_r  out  16  signed mixed output.
REQ-018 sample_valid  out  1  one-cycle pulse on output update.
REQ-019 voice_active  out  NUM_VOICES  per-voice playing flags.
REQ-020 overrun  out  1  sticky: tick arrived while frame busy.

Function
REQ-021 FSM states IDLE, SCAN, REQ, WAIT, ACC, DONE; IDLE->SCAN on sample_tick, clearing accumulators, voice index 0.
REQ-022 SCAN: inactive voice -> next index same-cycle decision; after index NUM_VOICES-1 -> DONE; active voice -> REQ.
REQ-023 REQ: mem_rd=1, mem_addr = SAMPLE_BASE + pos[ADDR_W+FRAC_W-1:FRAC_W] zero-extended, -> WAIT.
REQ-024 WAIT: mem_rd/mem_addr held stable; on mem_ready mem_rd=0 next cycle, latch mem_data, -> ACC.
REQ-025 ACC: acc_l += (data * vol_l) >>> 8, acc_r likewise (signed 16 x unsigned 8, 24-bit product, arithmetic shift); pos += incr; then SCAN at next index or DONE after last.
REQ-026 End handling: if new integer pos > end, loop bit set -> pos = {loop, FRAC_W'0}; else voice_active cleared, pos unchanged.
REQ-027 DONE: saturate acc to [-32768, 32767] into sample_l/r, sample_valid=1 one cycle, -> IDLE.
REQ-028 sample_tick while not IDLE: ignored, overrun set to 1 until reset.
REQ-029 ctrl write bit0=1: pos = {start, FRAC_W'0}, voice_active=1; bit0=0: voice_active=0 (key-off).
REQ-030 Host write and engine update to same voice same cycle: host write wins for every field it writes.
REQ-031 Key-off of voice in WAIT: transaction completes, sample still mixed, pos not reloaded.
REQ-032 incr=0: voice repeats same sample every frame; pos wrap at ADDR_W+FRAC_W bits is modulo.

Reset
REQ-033 reset_n=0: FSM IDLE, mem_rd=0, mem_addr=0, sample_l/r=0, sample_valid=0, voice_active=0, overrun=0, all voice registers 0.
REQ-034 Reset mid-WAIT: mem_rd drops next cycle; mem_ready arriving after reset release while IDLE is ignored.

Configuration
REQ-035 Macro ICS_VOICE_LOOP_EN defined: loop bit and loop registers honoured per REQ-026.
REQ-036 Macro undefined: loop storage not built, sel 5/6 and ctrl bit1 writes ignored, every voice stops at end.

Structure
REQ-037 Package ics_pkg holds FSM state enum, register-select constants, voice-record typedef, saturation function.
REQ-038 Sub-module ics_voice_regs: per-voice register file with host/engine write arbitration (REQ-030).

Verification
REQ-039 Voice 0 start 0x100, end 0x103, incr 0x0400, vol L=R=0x80, data=0x4000, 5 ticks -> four outputs 0x2000, then voice_active[0]=0, fifth output 0.
REQ-040 Same with loop=1, loop 0x101 -> mem_addr sequence 0x620100,101,102,103,101,102; voice stays active.
REQ-041 32 voices, data 0x7FFF, vol 0xFF -> sample_l=0x7FFF; data 0x8000 -> 0x8000 (saturation).
REQ-042 incr 0x0200 -> each address fetched on two consecutive frames.
REQ-043 Second sample_tick during WAIT with mem_ready delayed 2000 cycles -> overrun=1, single sample_valid.
REQ-044 reset_n low during WAIT, mem_ready 3 cycles after release -> no state change, outputs remain 0.
